// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared depth helper and fill-level type for the sync FIFO family.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int c_FIFO_ADDR_W = 5;

    // Fill level is one bit wider than the pointers so "full" is representable.
    typedef logic [c_FIFO_ADDR_W:0] fifo_count_t;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_mem_2p.sv
// ============================================================================
// Module   : fifo_mem_2p
// Purpose  : Simple dual-port array, synchronous write / asynchronous read.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int c_DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_mem_2p

`default_nettype wire

// File: rtl/fifo_sync_flags.sv
// ============================================================================
// Module   : fifo_sync_flags
// Purpose  : Single-clock FIFO with level flags, flush, sticky error flags
//            and selectable first-word-fall-through or registered read.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 9,
    parameter int ADDR_W    = 5,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = 28,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    input  logic              flush,
    input  logic              clr_err,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              c_DEPTH     = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(c_DEPTH);
    localparam logic [ADDR_W:0] c_AF_CNT    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] c_AE_CNT    = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0] c_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    generate
        if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > c_DEPTH) begin : g_bad_thresh
            $error("fifo_sync_flags: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= depth");
        end
    endgenerate

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rd_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH_CNT);

    // A write into a full FIFO is legal only when a pop frees a slot this cycle.
    assign w_rd_ok  = rd_en & ~w_empty;
    assign w_wr_ok  = wr_en & (~w_full | w_rd_ok);
    assign w_mem_we = w_wr_ok & ~flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // New errors take precedence over a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!flush) begin
            if (wr_en & ~w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en & w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rd_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data = w_mem_rd_data;
        end else begin : g_reg_rd
            logic [DATA_W-1:0] r_rd_data;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_rd_data <= '0;
                end else if (w_rd_ok && !flush) begin
                    r_rd_data <= w_mem_rd_data;
                end
            end

            assign rd_data = r_rd_data;
        end
    endgenerate

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= c_AE_CNT);
    assign almost_full  = (r_count >= c_AF_CNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : fifo_sync_flags

`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
// ============================================================================
// Module   : tb_fifo_sync_flags
// Purpose  : Directed self-checking bench for fifo_sync_flags (FWFT and
//            registered-read instances).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_sync_flags;
    import fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT instance
    logic        a_rstn, a_wr_en, a_rd_en, a_flush, a_clr_err;
    logic [8:0]  a_wr_data, a_rd_data;
    logic        a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
    fifo_count_t a_count;

    // Registered-read instance
    logic        b_rstn, b_wr_en, b_rd_en, b_flush, b_clr_err;
    logic [8:0]  b_wr_data, b_rd_data;
    logic        b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
    fifo_count_t b_count;

    int checks = 0;
    int errors = 0;

    fifo_sync_flags #(
        .DATA_W(9), .ADDR_W(5), .FWFT(1), .AF_THRESH(28), .AE_THRESH(4)
    ) u_dut_a (
        .clk(clk), .rstn(a_rstn), .wr_en(a_wr_en), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_data(a_rd_data), .flush(a_flush), .clr_err(a_clr_err),
        .empty(a_empty), .full(a_full), .almost_empty(a_ae), .almost_full(a_af),
        .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    fifo_sync_flags #(
        .DATA_W(9), .ADDR_W(5), .FWFT(0), .AF_THRESH(28), .AE_THRESH(4)
    ) u_dut_b (
        .clk(clk), .rstn(b_rstn), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .flush(b_flush), .clr_err(b_clr_err),
        .empty(b_empty), .full(b_full), .almost_empty(b_ae), .almost_full(b_af),
        .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [8:0] d);
        a_wr_en = 1'b1; a_wr_data = d;
        cyc();
        a_wr_en = 1'b0;
    endtask

    task automatic a_pop_chk(input string tag, input logic [8:0] d);
        chk(tag, 32'(a_rd_data), 32'(d));
        a_rd_en = 1'b1;
        cyc();
        a_rd_en = 1'b0;
    endtask

    initial begin
        a_rstn = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_flush = 1'b0; a_clr_err = 1'b0; a_wr_data = '0;
        b_rstn = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_flush = 1'b0; b_clr_err = 1'b0; b_wr_data = '0;
        cyc(); cyc();

        // Reset state
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_full",  32'(a_full),  32'd0);
        chk("rst_ae",    32'(a_ae),    32'd1);
        chk("rst_af",    32'(a_af),    32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_ovf",   32'(a_ovf),   32'd0);
        chk("rst_unf",   32'(a_unf),   32'd0);
        a_rstn = 1'b1;
        cyc();

        // Fill 0x001..0x020
        for (int i = 1; i <= 32; i++) begin
            a_push(9'(i));
            chk("fill_af", 32'(a_af), (i >= 28) ? 32'd1 : 32'd0);
        end
        chk("fill_full",  32'(a_full),    32'd1);
        chk("fill_count", 32'(a_count),   32'd32);
        chk("fill_head",  32'(a_rd_data), 32'h001);

        // Write while full
        a_push(9'h1FF);
        chk("ovf_set",   32'(a_ovf),   32'd1);
        chk("ovf_count", 32'(a_count), 32'd32);

        // Drain in order
        for (int i = 1; i <= 32; i++) begin
            a_pop_chk("drain_data", 9'(i));
            chk("drain_ae", 32'(a_ae), ((32 - i) <= 4) ? 32'd1 : 32'd0);
        end
        chk("drain_empty", 32'(a_empty), 32'd1);

        // Read while empty
        a_rd_en = 1'b1; cyc(); a_rd_en = 1'b0;
        chk("unf_set",   32'(a_unf),   32'd1);
        chk("unf_count", 32'(a_count), 32'd0);

        a_clr_err = 1'b1; cyc(); a_clr_err = 1'b0;
        chk("clr_ovf", 32'(a_ovf), 32'd0);
        chk("clr_unf", 32'(a_unf), 32'd0);

        // Full boundary: simultaneous read/write
        for (int i = 1; i <= 32; i++) a_push(9'(i));
        a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 9'h1AA;
        cyc();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        chk("fb_count", 32'(a_count), 32'd32);
        chk("fb_ovf",   32'(a_ovf),   32'd0);
        for (int i = 2; i <= 32; i++) a_pop_chk("fb_data", 9'(i));
        a_pop_chk("fb_last", 9'h1AA);
        chk("fb_empty", 32'(a_empty), 32'd1);

        // Empty boundary: simultaneous read/write
        a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 9'h055;
        cyc();
        a_wr_en = 1'b0; a_rd_en = 1'b0;
        chk("eb_count", 32'(a_count),   32'd1);
        chk("eb_unf",   32'(a_unf),     32'd1);
        chk("eb_data",  32'(a_rd_data), 32'h055);
        a_pop_chk("eb_pop", 9'h055);

        // Wrap: pointers run past 31
        for (int i = 1; i <= 20; i++) a_push(9'(9'h080 + i));
        for (int i = 1; i <= 20; i++) a_pop_chk("wrap_data1", 9'(9'h080 + i));
        for (int i = 1; i <= 20; i++) a_push(9'(9'h040 + i));
        for (int i = 1; i <= 10; i++) a_pop_chk("wrap_data2", 9'(9'h040 + i));
        chk("wrap_count", 32'(a_count), 32'd10);

        // Flush wins over a same-cycle write; sticky flags untouched
        a_flush = 1'b1; a_wr_en = 1'b1; a_wr_data = 9'h1EE;
        cyc();
        a_flush = 1'b0; a_wr_en = 1'b0;
        chk("fl_count", 32'(a_count), 32'd0);
        chk("fl_empty", 32'(a_empty), 32'd1);
        chk("fl_unf",   32'(a_unf),   32'd1);
        chk("fl_ovf",   32'(a_ovf),   32'd0);
        a_push(9'h033);
        chk("fl_post_count", 32'(a_count),   32'd1);
        chk("fl_post_data",  32'(a_rd_data), 32'h033);
        a_clr_err = 1'b1; cyc(); a_clr_err = 1'b0;
        chk("fl_clr_unf", 32'(a_unf), 32'd0);

        // Registered-read instance
        chk("b_rst_data", 32'(b_rd_data), 32'd0);
        b_rstn = 1'b1;
        cyc();
        b_wr_en = 1'b1;
        b_wr_data = 9'h00A; cyc();
        b_wr_data = 9'h00B; cyc();
        b_wr_data = 9'h00C; cyc();
        b_wr_en = 1'b0;
        chk("b_count3", 32'(b_count),   32'd3);
        chk("b_hold0",  32'(b_rd_data), 32'd0);
        b_rd_en = 1'b1; cyc(); b_rd_en = 1'b0;
        chk("b_rd_a",   32'(b_rd_data), 32'h00A);
        cyc();
        chk("b_hold_a", 32'(b_rd_data), 32'h00A);
        b_rd_en = 1'b1; cyc(); b_rd_en = 1'b0;
        chk("b_rd_b",   32'(b_rd_data), 32'h00B);
        chk("b_count1", 32'(b_count),   32'd1);

        // Asynchronous reset between clock edges
        #2 b_rstn = 1'b0;
        #1;
        chk("b_arst_count", 32'(b_count),   32'd0);
        chk("b_arst_empty", 32'(b_empty),   32'd1);
        chk("b_arst_data",  32'(b_rd_data), 32'd0);
        cyc();
        b_rstn = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_sync_flags

`default_nettype wire
